// File: rtl/muxn_pipe_pkg.sv
// Shared definitions for the registered N:1 select stage used at MIPS pipeline
// boundaries: input-count limits and the select legality helper.
package mips_mux_pkg;

    localparam int MAX_MUX_INPUTS = 16;
    localparam int MAX_SEL_WIDTH  = $clog2(MAX_MUX_INPUTS);

    // True when sel names an existing input of an n-input mux.
    function automatic logic sel_legal(input logic [MAX_SEL_WIDTH-1:0] sel,
                                       input int unsigned             n);
        return (32'(sel) < n);
    endfunction

endpackage

// File: rtl/muxn_pipe_if.sv
// Handshake bundle for muxn_pipe: upstream item/select side and registered
// downstream side. slave is the stage, master is whoever drives it.
interface muxn_pipe_if #(
    parameter int DATA_SIZE  = 32,
    parameter int NUM_INPUTS = 4
);
    localparam int SEL_WIDTH = $clog2(NUM_INPUTS);

    logic [NUM_INPUTS*DATA_SIZE-1:0] in_data;
    logic [SEL_WIDTH-1:0]            select;
    logic                            in_valid;
    logic                            in_ready;
    logic                            flush;
    logic [DATA_SIZE-1:0]            out_data;
    logic [SEL_WIDTH-1:0]            out_sel;
    logic                            sel_err;
    logic                            out_valid;
    logic                            out_ready;

    modport slave (
        input  in_data, select, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, sel_err, out_valid
    );

    modport master (
        output in_data, select, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, sel_err, out_valid
    );

endinterface

// File: rtl/muxn_pipe_muxn.sv
// Purely combinational N:1 selector; an out-of-range select falls back to
// input 0 and raises err.
module muxn
    import mips_mux_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int NUM_INPUTS = 4
) (
    input  logic [NUM_INPUTS*DATA_SIZE-1:0]  in_data,
    input  logic [$clog2(NUM_INPUTS)-1:0]    sel,
    output logic [DATA_SIZE-1:0]             data_o,
    output logic                             err_o
);

    // Select the addressed input, or input 0 with err for an illegal index.
    always_comb begin
        data_o = in_data[0 +: DATA_SIZE];
        err_o  = 1'b0;
        if (sel_legal(MAX_SEL_WIDTH'(sel), NUM_INPUTS)) begin
            data_o = in_data[int'(sel)*DATA_SIZE +: DATA_SIZE];
        end else begin
            err_o  = 1'b1;
        end
    end

endmodule

// File: rtl/muxn_pipe.sv
// Registered N:1 mux stage with valid/ready handshake, 2-entry storage (OUT +
// SKID) and synchronous flush; in_ready depends only on held state and reset.
module muxn_pipe
    import mips_mux_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int NUM_INPUTS = 4
) (
    input  logic         clk,
    input  logic         reset,
    muxn_pipe_if.slave   bus
);

    localparam int SEL_WIDTH = $clog2(NUM_INPUTS);

    typedef struct packed {
        logic [DATA_SIZE-1:0] data;
        logic [SEL_WIDTH-1:0] sel;
        logic                 err;
    } entry_t;

    logic [DATA_SIZE-1:0] mux_data;
    logic                 mux_err;
    entry_t               new_item;
    entry_t               out_q, out_d, skid_q, skid_d;
    logic                 out_valid_q, out_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic                 in_ready;
    logic                 accept;
    logic                 pop;

    muxn #(
        .DATA_SIZE  (DATA_SIZE),
        .NUM_INPUTS (NUM_INPUTS)
    ) u_muxn (
        .in_data (bus.in_data),
        .sel     (bus.select),
        .data_o  (mux_data),
        .err_o   (mux_err)
    );

    assign new_item = '{data: mux_data, sel: bus.select, err: mux_err};
    assign in_ready = !skid_valid_q && !reset;
    assign accept   = bus.in_valid && in_ready;
    assign pop      = out_valid_q && bus.out_ready;

    // Next-state for OUT and SKID; SKID only fills when OUT is stalled.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = new_item;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!out_valid_q) begin
            if (accept) begin
                out_d       = new_item;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (accept) begin
                skid_d       = new_item;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_q.data;
    assign bus.out_sel   = out_q.sel;
    assign bus.sel_err   = out_q.err;
    assign bus.out_valid = out_valid_q;

endmodule
